// File: rtl/div_sequencer.sv
// Iterative restoring divider controller, one quotient bit per cycle.
// Latency: W_OPR+1 cycles from accepted start to done_o (1 cycle for divide by zero).
// Backpressure: stall_o holds upstream while accepting/calculating; flush_i aborts.
module div_sequencer #(
  parameter int W_OPR   = 32,
  parameter int W_FLAGS = 4,
  parameter int W_CNT   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               v_i,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [W_OPR-1:0]   dividend_i,
  input  logic [W_OPR-1:0]   divisor_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [W_OPR-1:0]   quotient_o,
  output logic [W_OPR-1:0]   remainder_o,
  output logic [W_FLAGS-1:0] flags_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;
  logic [W_OPR-1:0]   dvd_q, dvd_d;         // shifting dividend, fills with quotient bits
  logic [W_OPR-1:0]   dsr_q, dsr_d;         // divisor magnitude
  logic [W_OPR-1:0]   rem_q, rem_d;         // partial remainder
  logic               quo_neg_q, quo_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               ovf_q, ovf_d;
  logic [W_OPR-1:0]   quo_q, quo_d;
  logic [W_OPR-1:0]   rmd_q, rmd_d;
  logic [W_FLAGS-1:0] flags_q, flags_d;
  logic               done_q, done_d;

  logic               accept;
  logic               a_sign, b_sign;
  logic [W_OPR-1:0]   a_mag, b_mag;
  logic [W_OPR:0]     rem_ext;
  logic               qbit;
  logic [W_OPR-1:0]   rem_nxt, quo_nxt, q_fin, r_fin;

  localparam logic [W_OPR-1:0] OPR_MIN = {1'b1, {(W_OPR-1){1'b0}}};

  function automatic logic [W_FLAGS-1:0] make_flags(input logic [W_OPR-1:0] q,
                                                   input logic dz, input logic ov);
    logic [W_FLAGS-1:0] f;
    f    = '0;
    f[0] = dz;
    f[1] = (q == '0);
    f[2] = q[W_OPR-1];
    f[3] = ov;
    return f;
  endfunction

  // Operand conditioning, one restoring step, and next-state selection.
  always_comb begin
    accept  = v_i & start_i & ~flush_i;
    a_sign  = signed_i & dividend_i[W_OPR-1];
    b_sign  = signed_i & divisor_i[W_OPR-1];
    a_mag   = a_sign ? (~dividend_i + W_OPR'(1)) : dividend_i;
    b_mag   = b_sign ? (~divisor_i + W_OPR'(1)) : divisor_i;

    // Compare at W_OPR+1 bits; after a successful subtract the result is
    // below the divisor, so the low W_OPR bits of the difference are exact.
    rem_ext = {rem_q, dvd_q[W_OPR-1]};
    qbit    = (rem_ext >= {1'b0, dsr_q});
    rem_nxt = qbit ? (rem_ext[W_OPR-1:0] - dsr_q) : rem_ext[W_OPR-1:0];
    quo_nxt = {dvd_q[W_OPR-2:0], qbit};
    q_fin   = quo_neg_q ? (~quo_nxt + W_OPR'(1)) : quo_nxt;
    r_fin   = rem_neg_q ? (~rem_nxt + W_OPR'(1)) : rem_nxt;

    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    ovf_d     = ovf_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    flags_d   = flags_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dvd_d     = a_mag;
          dsr_d     = b_mag;
          rem_d     = '0;
          cnt_d     = W_CNT'(W_OPR - 1);
          quo_neg_d = a_sign ^ b_sign;
          rem_neg_d = a_sign;
          ovf_d     = signed_i & (dividend_i == OPR_MIN) & (divisor_i == '1);
          if (divisor_i == '0) begin
            // Divide by zero resolves immediately without iterating.
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            rmd_d   = dividend_i;
            flags_d = make_flags('1, 1'b1, 1'b0);
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nxt;
          dvd_d = quo_nxt;
          if (cnt_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = q_fin;
            rmd_d   = r_fin;
            flags_d = make_flags(q_fin, 1'b0, ovf_q);
          end else begin
            cnt_d = cnt_q - W_CNT'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single state/datapath register bank with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      ovf_q     <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      ovf_q     <= ovf_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
    end
  end

  // A flush arriving in DONE swallows the completion pulse.
  always_comb begin
    stall_o     = ((state_q == IDLE) & accept) | (state_q == CALC);
    busy_o      = (state_q != IDLE);
    done_o      = done_q & ~flush_i;
    quotient_o  = quo_q;
    remainder_o = rmd_q;
    flags_o     = flags_q;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer with hand-computed expected results.
// Cycle T0 is the cycle start_i is presented; outputs sampled on falling edges.
// Every wait on the DUT is bounded by a cycle budget or a global timeout.
module tb_div_sequencer;

  logic        clk;
  logic        reset;
  logic        v_i, start_i, signed_i, flush_i;
  logic [31:0] dividend_i, divisor_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] quotient_o, remainder_o;
  logic [3:0]  flags_o;

  int n_vec;
  int n_err;

  div_sequencer #(.W_OPR(32), .W_FLAGS(4), .W_CNT(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .v_i         (v_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .flags_o     (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one divide at T0, track stall cycles and done timing, check results.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic [3:0] ef, input int edone);
    int dcyc;
    int nstall;
    @(posedge clk); #1;
    v_i = 1'b1; start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    @(negedge clk);
    nstall = int'(stall_o);
    dcyc   = -1;
    @(posedge clk); #1;
    v_i = 1'b0; start_i = 1'b0; dividend_i = 32'hDEADBEEF; divisor_i = 32'h0BADF00D;
    for (int t = 1; t <= 40 && dcyc < 0; t++) begin
      @(negedge clk);
      nstall += int'(stall_o);
      if (done_o) dcyc = t;
    end
    chk({tag, ".done_cycle"}, dcyc, edone);
    chk({tag, ".stall_cycles"}, nstall, edone);
    chk({tag, ".quotient"}, quotient_o, eq);
    chk({tag, ".remainder"}, remainder_o, er);
    chk({tag, ".flags"}, {28'd0, flags_o}, {28'd0, ef});
    @(negedge clk);
    chk({tag, ".done_pulse_end"}, {31'd0, done_o}, 32'd0);
    chk({tag, ".idle_after"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int ndone;
    n_vec = 0; n_err = 0;
    reset = 1'b0; v_i = 1'b0; start_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0;
    dividend_i = '0; divisor_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.stall", {31'd0, stall_o}, 32'd0);
    chk("rst.busy", {31'd0, busy_o}, 32'd0);
    chk("rst.done", {31'd0, done_o}, 32'd0);
    chk("rst.quotient", quotient_o, 32'd0);
    chk("rst.remainder", remainder_o, 32'd0);
    chk("rst.flags", {28'd0, flags_o}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 33);
    run_div("s-100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 4'b0100, 33);
    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 4'b1100, 33);
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 4'b0100, 33);
    run_div("u_big", 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0000, 33);
    run_div("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 4'b0101, 1);

    // Flush mid-calculation: 1000/3 started at T0, flush_i during T10
    @(posedge clk); #1;
    v_i = 1'b1; start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    @(posedge clk); #1;
    v_i = 1'b0; start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    chk("flush.stall_T10", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush.stall_T11", {31'd0, stall_o}, 32'd0);
    chk("flush.busy_T11", {31'd0, busy_o}, 32'd0);
    chk("flush.quotient_kept", quotient_o, 32'hFFFFFFFF);
    chk("flush.remainder_kept", remainder_o, 32'd5);
    chk("flush.flags_kept", {28'd0, flags_o}, 32'h5);
    ndone = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      ndone += int'(done_o);
    end
    chk("flush.no_done", ndone, 0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 4'b0000, 33);

    // Start ignored while busy: second request during CALC must not alter result
    @(posedge clk); #1;
    v_i = 1'b1; start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5;
    @(posedge clk); #1;
    dividend_i = 32'd77; divisor_i = 32'd2;
    repeat (3) @(posedge clk);
    #1 v_i = 1'b0; start_i = 1'b0;
    ndone = 0;
    for (int t = 0; t < 40 && ndone == 0; t++) begin
      @(negedge clk);
      ndone += int'(done_o);
    end
    chk("busy_start.done_seen", ndone, 1);
    chk("busy_start.quotient", quotient_o, 32'd10);
    chk("busy_start.remainder", remainder_o, 32'd0);

    // Async reset mid-operation: 3/5 started at T0, reset low at T5
    repeat (3) @(posedge clk);
    #1;
    v_i = 1'b1; start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd3; divisor_i = 32'd5;
    @(posedge clk); #1;
    v_i = 1'b0; start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("arst.busy_T4", {31'd0, busy_o}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("arst.quotient", quotient_o, 32'd0);
    chk("arst.busy", {31'd0, busy_o}, 32'd0);
    chk("arst.stall", {31'd0, stall_o}, 32'd0);
    chk("arst.flags", {28'd0, flags_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ndone = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      ndone += int'(done_o);
    end
    chk("arst.no_done", ndone, 0);
    run_div("u3_5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd3, 4'b0010, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
